tdm_demux: RTL and testbench

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_demux.sv | 81 ++++++++
 tb/tb_tdm_demux.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// tdm_demux: splits a time-multiplexed sample stream into whole frames of CHANNELS slots
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_sync   sample qualifier, slot-0 marker (meaningful only with in_valid)
//   in_data             incoming sample
//   out_data, out_valid assembled frame (slot k at [k*WIDTH +: WIDTH]) and its valid flag
//   out_ready           consumer accepts out_data
//   locked              frame alignment held
//   sync_err, overrun   one-cycle event pulses
module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_sync,
  input  logic [WIDTH-1:0]          in_data,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      locked,
  output logic                      sync_err,
  output logic                      overrun
);
  localparam int CW = $clog2(CHANNELS);
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);
  typedef enum logic {HUNT, LOCK} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, slot;
  logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, locked_q, locked_d;
  logic sync_err_q, sync_err_d, overrun_q, overrun_d;
  logic store, complete;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= HUNT;
    else state_q <= state_d;
  // HUNT waits for a sync; LOCK falls back only when a frame boundary arrives without sync
  always_comb
    state_d = !in_valid ? state_q :
              state_q == HUNT ? (in_sync ? LOCK : HUNT) :
              (!in_sync && cnt_q == '0) ? HUNT : LOCK;
  always_comb begin
    store      = in_valid && (in_sync || (state_q == LOCK && cnt_q != '0));
    slot       = in_sync ? '0 : cnt_q;
    // only a non-sync sample landing in the last slot completes a frame
    complete   = store && !in_sync && cnt_q == LAST;
    cnt_d      = !store ? cnt_q : in_sync ? CW'(1) : complete ? '0 : cnt_q + 1'b1;
    shadow_d   = shadow_q;
    if (store) shadow_d[int'(slot)*WIDTH +: WIDTH] = in_data;
    sync_err_d = in_valid && state_q == LOCK && (in_sync ? cnt_q != '0 : cnt_q == '0);
    locked_d   = state_d == LOCK;
    // the final sample bypasses the shadow so the frame appears one edge after it
    out_data_d  = complete ? {in_data, shadow_q[(CHANNELS-1)*WIDTH-1:0]} : out_data_q;
    out_valid_d = complete || (out_valid_q && !out_ready);
    overrun_d   = complete && out_valid_q && !out_ready;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q       <= '0;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
      overrun_q   <= overrun_d;
    end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign locked    = locked_q;
  assign sync_err  = sync_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed frame-demux checks with an expected-frame scoreboard
module tb_tdm_demux;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sync = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic [31:0] out_data;
  logic out_valid, locked, sync_err, overrun;
  int total = 0, bad = 0;
  logic [31:0] sb[$];
  logic [31:0] held;
  always #5 clk = ~clk;
  tdm_demux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sync(in_sync), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .locked(locked), .sync_err(sync_err), .overrun(overrun)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_frame(input string tag);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sb"}, sb.size() != 0, 1);
    if (sb.size() != 0) chk({tag, "_data"}, out_data, sb.pop_front());
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_serr"}, sync_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask
  initial begin
    #1;
    all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 8'h00);
    chk("idle_locked", locked, 0);
    // basic frame capture
    step(1, 1, 8'h11);
    chk("cap_locked", locked, 1);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    chk("cap_early_valid", out_valid, 0);
    sb.push_back(32'h44332211);
    step(1, 0, 8'h44);
    expect_frame("cap");
    step(0, 0, 8'h00);
    chk("cap_one_cycle", out_valid, 0);
    // missing sync at frame boundary
    step(1, 0, 8'h99);
    chk("miss_serr", sync_err, 1);
    chk("miss_locked", locked, 0);
    chk("miss_valid", out_valid, 0);
    step(0, 0, 8'h00);
    chk("miss_serr_pulse", sync_err, 0);
    // hunting, then a frame with bubbles
    step(1, 0, 8'hAA);
    step(1, 0, 8'hBB);
    chk("hunt_locked", locked, 0);
    chk("hunt_valid", out_valid, 0);
    step(1, 1, 8'h01);
    step(0, 1, 8'hEE);
    step(1, 0, 8'h02);
    step(0, 0, 8'hEE);
    step(1, 0, 8'h03);
    step(0, 1, 8'hEE);
    chk("gap_valid", out_valid, 0);
    sb.push_back(32'h04030201);
    step(1, 0, 8'h04);
    expect_frame("gap");
    step(0, 0, 8'h00);
    // early sync restarts the frame
    step(1, 1, 8'h10);
    step(1, 0, 8'h20);
    step(1, 1, 8'h30);
    chk("early_serr", sync_err, 1);
    chk("early_locked", locked, 1);
    step(1, 0, 8'h40);
    chk("early_serr_pulse", sync_err, 0);
    step(1, 0, 8'h50);
    sb.push_back(32'h60504030);
    step(1, 0, 8'h60);
    expect_frame("early");
    chk("early_locked2", locked, 1);
    step(0, 0, 8'h00);
    // backpressure and overrun
    out_ready = 1'b0;
    step(1, 1, 8'hA1);
    step(1, 0, 8'hA2);
    step(1, 0, 8'hA3);
    sb.push_back(32'hA4A3A2A1);
    step(1, 0, 8'hA4);
    held = out_data;
    expect_frame("bp1");
    chk("bp1_ovr", overrun, 0);
    step(0, 0, 8'h00);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, held);
    step(1, 1, 8'hB1);
    step(1, 0, 8'hB2);
    step(1, 0, 8'hB3);
    sb.push_back(32'hB4B3B2B1);
    step(1, 0, 8'hB4);
    expect_frame("bp2");
    chk("bp2_ovr", overrun, 1);
    step(0, 0, 8'h00);
    chk("bp2_ovr_pulse", overrun, 0);
    chk("bp2_still_valid", out_valid, 1);
    out_ready = 1'b1;
    step(0, 0, 8'h00);
    chk("bp_release", out_valid, 0);
    // completion coinciding with acceptance
    out_ready = 1'b0;
    step(1, 1, 8'hC1);
    step(1, 0, 8'hC2);
    step(1, 0, 8'hC3);
    sb.push_back(32'hC4C3C2C1);
    step(1, 0, 8'hC4);
    expect_frame("acc1");
    step(1, 1, 8'hD1);
    step(1, 0, 8'hD2);
    step(1, 0, 8'hD3);
    out_ready = 1'b1;
    sb.push_back(32'hD4D3D2D1);
    step(1, 0, 8'hD4);
    expect_frame("acc2");
    chk("acc2_ovr", overrun, 0);
    // asynchronous reset mid-frame
    out_ready = 1'b0;
    step(1, 1, 8'hE1);
    step(1, 0, 8'hE2);
    chk("rst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("rst_async");
    step(1, 1, 8'hF1);
    step(0, 0, 8'h00);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(1, 0, 8'h05);
    step(1, 0, 8'h06);
    all_zero("rst_after");
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
